// File: rtl/timer_pkg.sv
// Shared timer definitions: the per-channel edge-select encoding and the default counter width.
package timer_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_sel_t;

  localparam int DEF_COUNTER_SIZE = 32;

  // True when the selection reacts to a rising edge.
  function automatic logic sel_has_rise(input edge_sel_t sel);
    return (sel == EDGE_RISE) || (sel == EDGE_BOTH);
  endfunction

  // True when the selection reacts to a falling edge.
  function automatic logic sel_has_fall(input edge_sel_t sel);
    return (sel == EDGE_FALL) || (sel == EDGE_BOTH);
  endfunction

endpackage

// File: rtl/input_filter.sv
// Input conditioning for the capture pin: a metastability synchroniser followed by a
// glitch filter that accepts a new level only after FILTER_LEN consecutive differing samples.
// rise_evt/fall_evt are asserted in the cycle whose clock edge commits the new level.
module input_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise_evt,
  output logic fall_evt
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt;
  logic                   smp;
  logic                   accept;

  assign smp      = sync_q[SYNC_STAGES-1];
  assign accept   = (smp != level) && (cnt == CNT_LAST);
  assign rise_evt = accept && smp;
  assign fall_evt = accept && !smp;

  // Shift the asynchronous pin through the synchroniser chain.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  // Count consecutive differing samples; commit the new level on the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (smp == level) begin
      cnt <= '0;
    end else if (accept) begin
      level <= smp;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/input_capture.sv
// Timer input-capture unit: filters the external pin, latches counter_value into per-channel
// capture registers on the selected edges, keeps flag/overrun status and, in PWM-input mode,
// derives period and high width of the pin from channel 0 (rise) and channel 1 (fall).
module input_capture
  import timer_pkg::*;
#(
  parameter int COUNTER_SIZE = DEF_COUNTER_SIZE,
  parameter int NUM_CAP      = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_LEN   = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   en,
  input  logic                                   cap_in,
  input  logic [COUNTER_SIZE-1:0]                counter_value,
  input  logic [NUM_CAP-1:0][1:0]                edge_sel,
  input  logic                                   pwm_in_mode,
  input  logic [NUM_CAP-1:0]                     intr_en,
  input  logic [NUM_CAP-1:0]                     flag_clr,
  output logic [NUM_CAP-1:0][COUNTER_SIZE-1:0]   capture_value,
  output logic [NUM_CAP-1:0]                     cap_flag,
  output logic [NUM_CAP-1:0]                     overrun,
  output logic [NUM_CAP-1:0]                     intr,
  output logic [COUNTER_SIZE-1:0]                period,
  output logic [COUNTER_SIZE-1:0]                pulse_width,
  output logic                                   meas_valid,
  output logic                                   level
);

  logic               rise_evt;
  logic               fall_evt;
  logic [NUM_CAP-1:0] fire;
  logic               armed;

  input_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_filter (
    .clk      (clk),
    .rst      (rst),
    .din      (cap_in),
    .level    (level),
    .rise_evt (rise_evt),
    .fall_evt (fall_evt)
  );

  assign intr = intr_en & cap_flag;

  for (genvar a = 0; a < NUM_CAP; a++) begin : g_ch
    edge_sel_t sel;

    // Effective edge selection: PWM-input mode pins ch0 to rise and ch1 to fall.
    always_comb begin
      // NOTE: give every always_comb output a default first so no path can infer a latch.
      sel = edge_sel_t'(edge_sel[a]);
      if (pwm_in_mode && (a == 0)) sel = EDGE_RISE;
      if (pwm_in_mode && (a == 1)) sel = EDGE_FALL;
    end

    assign fire[a] = en && ((rise_evt && sel_has_rise(sel)) || (fall_evt && sel_has_fall(sel)));

    // Capture register and status flags; a capture overrides a simultaneous clear.
    always_ff @(posedge clk) begin
      // NOTE: capture registers are architecturally visible outputs, so they are reset like any other flop.
      if (rst) begin
        capture_value[a] <= '0;
        cap_flag[a]      <= 1'b0;
        overrun[a]       <= 1'b0;
      end else if (fire[a]) begin
        capture_value[a] <= counter_value;
        cap_flag[a]      <= 1'b1;
        overrun[a]       <= cap_flag[a] && !flag_clr[a];
      end else if (flag_clr[a]) begin
        cap_flag[a] <= 1'b0;
        overrun[a]  <= 1'b0;
      end
    end
  end

  // PWM-input measurement: differences against the last rising capture held in channel 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed       <= 1'b0;
      period      <= '0;
      pulse_width <= '0;
      meas_valid  <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (!pwm_in_mode || !en) begin
        armed <= 1'b0;
      end else if (rise_evt) begin
        if (armed) begin
          period     <= counter_value - capture_value[0];
          meas_valid <= 1'b1;
        end
        armed <= 1'b1;
      end else if (fall_evt && armed) begin
        pulse_width <= counter_value - capture_value[0];
        meas_valid  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_input_capture.sv
// Directed self-checking bench for input_capture with default parameters
// (32-bit counter, 2 channels, 2 sync stages, filter length 4 -> 6-clock capture latency).
module tb_input_capture;
  import timer_pkg::*;

  localparam int CW = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic                en;
  logic                cap_in;
  logic [CW-1:0]       counter_value;
  logic [1:0][1:0]     edge_sel;
  logic                pwm_in_mode;
  logic [1:0]          intr_en;
  logic [1:0]          flag_clr;
  logic [1:0][CW-1:0]  capture_value;
  logic [1:0]          cap_flag;
  logic [1:0]          overrun;
  logic [1:0]          intr;
  logic [CW-1:0]       period;
  logic [CW-1:0]       pulse_width;
  logic                meas_valid;
  logic                level;

  logic [CW-1:0] cyc = '0;
  logic [CW-1:0] offset = '0;
  int            n_checks = 0;
  int            n_errors = 0;

  input_capture dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .cap_in        (cap_in),
    .counter_value (counter_value),
    .edge_sel      (edge_sel),
    .pwm_in_mode   (pwm_in_mode),
    .intr_en       (intr_en),
    .flag_clr      (flag_clr),
    .capture_value (capture_value),
    .cap_flag      (cap_flag),
    .overrun       (overrun),
    .intr          (intr),
    .period        (period),
    .pulse_width   (pulse_width),
    .meas_valid    (meas_valid),
    .level         (level)
  );

  always #5 clk = ~clk;

  // Free-running timer model: counts clock edges since time zero.
  always @(posedge clk) cyc <= cyc + 1;
  assign counter_value = cyc + offset;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges and land 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_flags();
    flag_clr = 2'b11;
    tick(1);
    flag_clr = 2'b00;
  endtask

  logic [CW-1:0] e0, e1, e2, r, last_rise;

  initial begin
    rst = 1'b1; en = 1'b0; cap_in = 1'b0; edge_sel = '0;
    pwm_in_mode = 1'b0; intr_en = '0; flag_clr = '0;
    tick(3);

    // Reset state
    check("rst_cap0",   capture_value[0], 0);
    check("rst_cap1",   capture_value[1], 0);
    check("rst_flag",   cap_flag, 0);
    check("rst_ovr",    overrun, 0);
    check("rst_intr",   intr, 0);
    check("rst_period", period, 0);
    check("rst_width",  pulse_width, 0);
    check("rst_mv",     meas_valid, 0);
    check("rst_level",  level, 0);
    rst = 1'b0;

    // 1. Rising edge at edge 100 -> capture 105 at edge 106
    en = 1'b1; edge_sel[0] = EDGE_RISE; intr_en = 2'b01;
    while (cyc < 100) tick(1);
    cap_in = 1'b1;
    tick(5);
    check("t1_flag_early", cap_flag[0], 0);
    tick(1);
    check("t1_cap",   capture_value[0], 105);
    check("t1_flag",  cap_flag, 2'b01);
    check("t1_intr",  intr, 2'b01);
    check("t1_level", level, 1);
    intr_en = 2'b00; #1;
    check("t1_intr_off", intr, 2'b00);
    clear_flags();
    check("t1_clr", cap_flag, 2'b00);
    check("t1_keep", capture_value[0], 105);
    cap_in = 1'b0;
    tick(10);
    check("t1_fall_ignored", cap_flag, 2'b00);

    // 2. Glitch filter: 3-cycle pulse rejected, 4-cycle pulse accepted
    edge_sel[0] = EDGE_RISE; edge_sel[1] = EDGE_FALL;
    cap_in = 1'b1; tick(3); cap_in = 1'b0;
    tick(10);
    check("t2_glitch_level", level, 0);
    check("t2_glitch_flag",  cap_flag, 2'b00);
    e0 = counter_value;
    cap_in = 1'b1; tick(4); cap_in = 1'b0;
    e1 = counter_value;
    tick(10);
    check("t2_rise_cap", capture_value[0], e0 + 5);
    check("t2_fall_cap", capture_value[1], e1 + 5);
    check("t2_flags",    cap_flag, 2'b11);
    check("t2_ovr",      overrun, 2'b00);
    check("t2_level",    level, 0);
    clear_flags();

    // 3. Overrun, then clear colliding with a capture
    edge_sel[1] = EDGE_OFF;
    cap_in = 1'b1; tick(10); cap_in = 1'b0; tick(10);
    e1 = counter_value;
    cap_in = 1'b1; tick(10); cap_in = 1'b0; tick(10);
    check("t3_ovr",  overrun[0], 1);
    check("t3_cap",  capture_value[0], e1 + 5);
    check("t3_flag", cap_flag[0], 1);
    e2 = counter_value;
    cap_in = 1'b1;
    tick(5);
    flag_clr = 2'b01;
    tick(1);
    flag_clr = 2'b00;
    check("t3_collide_flag", cap_flag[0], 1);
    check("t3_collide_ovr",  overrun[0], 0);
    check("t3_collide_cap",  capture_value[0], e2 + 5);
    cap_in = 1'b0; tick(10);
    clear_flags();
    check("t3_clr_flag", cap_flag[0], 0);
    check("t3_clr_keep", capture_value[0], e2 + 5);

    // 4. PWM-input mode: 30 high / 70 low
    edge_sel = '0;
    pwm_in_mode = 1'b1;
    tick(2);
    cap_in = 1'b1; tick(30); cap_in = 1'b0; tick(70);
    check("t4_width1",  pulse_width, 30);
    check("t4_period0", period, 0);
    cap_in = 1'b1;
    tick(6);
    check("t4_period", period, 100);
    check("t4_mv",     meas_valid, 1);
    tick(1);
    check("t4_mv_pulse", meas_valid, 0);
    tick(23); cap_in = 1'b0; tick(70);
    check("t4_width2", pulse_width, 30);

    // 4b. Re-arm after leaving the mode, then a rise pair across the counter wrap
    pwm_in_mode = 1'b0; tick(2);
    pwm_in_mode = 1'b1; tick(2);
    offset = 32'hFFFF_FFEB - cyc;
    cap_in = 1'b1;
    tick(6);
    check("t4_rearm_no_mv", meas_valid, 0);
    check("t4_wrap_cap0",   capture_value[0], 32'hFFFF_FFF0);
    tick(24); cap_in = 1'b0; tick(70);
    cap_in = 1'b1;
    tick(6);
    check("t4_wrap_cap1",   capture_value[0], 32'h0000_0054);
    check("t4_wrap_period", period, 32'h64);
    check("t4_wrap_mv",     meas_valid, 1);
    pwm_in_mode = 1'b0;
    offset = '0;
    cap_in = 1'b0; tick(10);
    clear_flags();

    // 5a. Pin changes while disabled produce no capture once enabled
    edge_sel[0] = EDGE_BOTH; edge_sel[1] = EDGE_BOTH;
    en = 1'b0; cap_in = 1'b1;
    tick(10);
    check("t5_dis_level", level, 1);
    check("t5_dis_flag",  cap_flag, 2'b00);
    en = 1'b1;
    tick(10);
    check("t5_en_flag", cap_flag, 2'b00);
    en = 1'b0; cap_in = 1'b0; tick(10); en = 1'b1;

    // 5b. Reset in the middle of a filter count
    edge_sel[0] = EDGE_RISE; edge_sel[1] = EDGE_OFF;
    cap_in = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    r = cyc;
    check("t5_rst_cap0",   capture_value[0], 0);
    check("t5_rst_flag",   cap_flag, 0);
    check("t5_rst_period", period, 0);
    check("t5_rst_width",  pulse_width, 0);
    check("t5_rst_level",  level, 0);
    tick(5);
    check("t5_rst_early", cap_flag[0], 0);
    tick(1);
    check("t5_rst_cap", capture_value[0], r + 5);
    check("t5_rst_flag2", cap_flag[0], 1);
    clear_flags();
    tick(12);

    // 6. ch1 on both edges, ch0 on rise, toggling every 20 clocks
    edge_sel[1] = EDGE_BOTH;
    last_rise = capture_value[0] == (r + 5) ? r + 5 : r + 5;
    for (int i = 0; i < 4; i++) begin
      e0 = counter_value;
      cap_in = ~cap_in;
      if (cap_in) last_rise = e0 + 5;
      tick(6);
      check($sformatf("t6_ch1_%0d", i), capture_value[1], e0 + 5);
      check($sformatf("t6_ch0_%0d", i), capture_value[0], last_rise);
      check($sformatf("t6_flag1_%0d", i), cap_flag[1], 1);
      clear_flags();
      tick(13);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
